request_scheduler: RTL and testbench
====================================

// Module: request_scheduler
// PURPOSE
//   Collects cabin and hall call buttons for the 4-storey car and schedules the state
//   controller's work.
//   - Latches each press as a pending request.
//   - Produces allReq_reg (stop mask) and up_need/down_need using SCAN ordering:
//     keep the current direction while requests lie ahead.
//   - Clears requests served when the door opens at a floor.
//   - Sits between the button inputs and state_control, which consumes allReq_reg,
//     up_need and down_need.
// PARAMETERS
//   N_FLOOR   4   floor count; width of every one-hot floor vector (bit0 = floor 1)
//   SYNC_LEN  2   synchronizer flops per button input (>=2)
// PORTS
//   clk         in   1        system clock (32 Hz domain)
//   rst_n       in   1        asynchronous active-low reset
//   switch      in   1        elevator master switch; 0 = flush all requests
//   cab_btn     in   N_FLOOR  cabin floor buttons, async, level, 1 = pressed
//   hall_up     in   N_FLOOR  hall up buttons; bit N_FLOOR-1 is ignored
//   hall_dn     in   N_FLOOR  hall down buttons; bit0 is ignored
//   position    in   N_FLOOR  one-hot current floor, from state_control
//   opendoor    in   1        door-open command, from state_control
//   allReq_reg  out  N_FLOOR  OR of all pending requests, per floor
//   up_need     out  1        schedule upward move
//   down_need   out  1        schedule downward move
//   cab_lamp    out  N_FLOOR  pending cabin requests
//   up_lamp     out  N_FLOOR  pending hall-up requests
//   dn_lamp     out  N_FLOOR  pending hall-down requests
// BEHAVIOUR
//   Reset (rst_n=0, async):
//     - all pending regs, sync flops, edge regs and outputs = 0
//     - last_dir = UP
//   Capture:
//     - each button passes through SYNC_LEN flops
//     - a rising edge of the synced level sets the pending bit
//     - holding a button does not re-arm it
//     - press at edge of cycle k -> pending/lamp high at cycle k+SYNC_LEN+1
//   Ignored inputs: up_lamp[N_FLOOR-1] and dn_lamp[0] are constant 0.
//   Serving (opendoor=1, evaluated each cycle while high):
//     - cab[pos] cleared
//     - up[pos] cleared if last_dir==UP or there is no request below pos
//     - dn[pos] cleared if last_dir==DOWN or there is no request above pos
//     - set/clear collision on the same bit in the same cycle: clear wins
//       (a press while the door is open at that floor is absorbed)
//   Masks, for one-hot pos:
//     - below = pos-1
//     - above = ~(pos | (pos-1)) over N_FLOOR bits
//     - req = cab | up | dn
//     - allReq_reg = req (registered, same cycle as pending)
//   Scheduler (registered; outputs update 1 clk after req/position change):
//     - if switch==0 or opendoor==1: up_need = down_need = 0
//     - elif last_dir==UP   and |(req&above): up_need=1
//     - elif last_dir==DOWN and |(req&below): down_need=1
//     - elif |(req&above): up_need=1, last_dir<=UP
//     - elif |(req&below): down_need=1, last_dir<=DOWN
//     - else both 0; last_dir holds
//     - up_need and down_need are never 1 together
//   Invalid position (zero or multi-hot):
//     - no clears; up_need = down_need = 0
//     - pending requests are held
//   switch==0 (synchronous): clear pending regs and needs; last_dir <= UP.
//     Buttons pressed while switch==0 are dropped.
//   rst_n asserted mid-operation: immediate clear; no stale request survives.
// TESTING
//   T1 reset: rst_n=0 with buttons held
//      -> all outputs 0; after release, no capture until a new rising edge.
//   T2 cab_btn=4'b1000 pulse at pos=0001
//      -> cab_lamp[3]=1 after 3 clk; allReq_reg=1000; up_need=1 on next clk;
//      then opendoor at pos=1000 -> cab_lamp=0, up_need=0.
//   T3 SCAN hold: pos=0010, last_dir=UP, requests at floors 1 and 4
//      -> up_need=1, down_need=0;
//      after floor 4 is served -> down_need=1.
//   T4 direction clear: pos=0100, up[2] and dn[2] pending, last_dir=UP, req above
//      -> opendoor clears up[2] only; dn_lamp[2] stays 1.
//   T5 collision: press cab_btn[1] while opendoor=1 at pos=0010
//      -> cab_lamp[1] stays 0.
//   T6 switch: drop switch with 3 pending requests
//      -> all lamps 0 and needs 0 on the next clk;
//      hall_up[3] / hall_dn[0] presses never set a lamp.

Source files
------------

// File: rtl/request_scheduler_if.sv
// Button, floor and scheduling signals between the car buttons,
// state_control and the request scheduler.
interface request_scheduler_if #(
    parameter int N_FLOOR = 4
);
    logic               switch;
    logic [N_FLOOR-1:0] cab_btn;
    logic [N_FLOOR-1:0] hall_up;
    logic [N_FLOOR-1:0] hall_dn;
    logic [N_FLOOR-1:0] position;
    logic               opendoor;
    logic [N_FLOOR-1:0] allReq_reg;
    logic               up_need;
    logic               down_need;
    logic [N_FLOOR-1:0] cab_lamp;
    logic [N_FLOOR-1:0] up_lamp;
    logic [N_FLOOR-1:0] dn_lamp;

    modport master (
        output switch, cab_btn, hall_up, hall_dn,
        output position, opendoor,
        input  allReq_reg, up_need, down_need,
        input  cab_lamp, up_lamp, dn_lamp
    );

    modport slave (
        input  switch, cab_btn, hall_up, hall_dn,
        input  position, opendoor,
        output allReq_reg, up_need, down_need,
        output cab_lamp, up_lamp, dn_lamp
    );
endinterface

// File: rtl/request_scheduler.sv
// Latches cabin/hall calls and produces SCAN-ordered up/down needs
// plus the per-floor stop mask for state_control.
module request_scheduler #(
    parameter int N_FLOOR  = 4,
    parameter int SYNC_LEN = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    request_scheduler_if.slave  bus
);
    localparam int W = 3 * N_FLOOR;
    localparam logic [N_FLOOR-1:0] UP_OK =
        {1'b0, {(N_FLOOR-1){1'b1}}};
    localparam logic [N_FLOOR-1:0] DN_OK =
        {{(N_FLOOR-1){1'b1}}, 1'b0};

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

    logic [SYNC_LEN-1:0][W-1:0] sync_q;
    logic [W-1:0]               lvl_q;
    logic [W-1:0]               rise_q;
    logic [SYNC_LEN:0]          prime_q;

    logic [N_FLOOR-1:0] cab_q, cab_d;
    logic [N_FLOOR-1:0] up_q, up_d;
    logic [N_FLOOR-1:0] dn_q, dn_d;
    logic               upn_q, upn_d;
    logic               dnn_q, dnn_d;
    dir_e               dir_q, dir_d;

    logic [N_FLOOR-1:0] pos, below, above, req;
    logic [N_FLOOR-1:0] clr_cab, clr_up, clr_dn;
    logic [N_FLOOR-1:0] set_cab, set_up, set_dn;
    logic               pos_ok, serve, req_blw, req_abv;

    assign pos     = bus.position;
    assign pos_ok  = (pos != '0) && ((pos & (pos - 1'b1)) == '0);
    assign below   = pos - 1'b1;
    assign above   = ~(pos | below);
    assign req     = cab_q | up_q | dn_q;
    assign req_blw = |(req & below);
    assign req_abv = |(req & above);
    assign serve   = bus.opendoor & pos_ok;

    assign set_cab = rise_q[N_FLOOR-1:0];
    assign set_up  = rise_q[2*N_FLOOR-1:N_FLOOR] & UP_OK;
    assign set_dn  = rise_q[W-1:2*N_FLOOR] & DN_OK;

    // Synchronize buttons and detect rising edges; priming keeps a
    // button held through reset from looking like a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            lvl_q   <= '0;
            rise_q  <= '0;
            prime_q <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_LEN-2:0],
                        {bus.hall_dn, bus.hall_up, bus.cab_btn}};
            lvl_q   <= sync_q[SYNC_LEN-1];
            prime_q <= {prime_q[SYNC_LEN-1:0], 1'b1};
            rise_q  <= prime_q[SYNC_LEN]
                     ? (sync_q[SYNC_LEN-1] & ~lvl_q) : '0;
        end
    end

    // Pending sets/clears (clear wins) and the SCAN direction choice.
    always_comb begin
        clr_cab = '0;
        clr_up  = '0;
        clr_dn  = '0;
        upn_d   = 1'b0;
        dnn_d   = 1'b0;
        dir_d   = dir_q;
        if (serve) begin
            clr_cab = pos;
            if (dir_q == DIR_UP || !req_blw) clr_up = pos;
            if (dir_q == DIR_DN || !req_abv) clr_dn = pos;
        end
        cab_d = (cab_q | set_cab) & ~clr_cab;
        up_d  = (up_q  | set_up)  & ~clr_up;
        dn_d  = (dn_q  | set_dn)  & ~clr_dn;
        if (!bus.switch) begin
            cab_d = '0;
            up_d  = '0;
            dn_d  = '0;
            dir_d = DIR_UP;
        end else if (bus.opendoor || !pos_ok) begin
            upn_d = 1'b0;
        end else if (dir_q == DIR_UP && req_abv) begin
            upn_d = 1'b1;
        end else if (dir_q == DIR_DN && req_blw) begin
            dnn_d = 1'b1;
        end else if (req_abv) begin
            upn_d = 1'b1;
            dir_d = DIR_UP;
        end else if (req_blw) begin
            dnn_d = 1'b1;
            dir_d = DIR_DN;
        end
    end

    // Pending request, need and direction registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cab_q <= '0;
            up_q  <= '0;
            dn_q  <= '0;
            upn_q <= 1'b0;
            dnn_q <= 1'b0;
            dir_q <= DIR_UP;
        end else begin
            cab_q <= cab_d;
            up_q  <= up_d;
            dn_q  <= dn_d;
            upn_q <= upn_d;
            dnn_q <= dnn_d;
            dir_q <= dir_d;
        end
    end

    assign bus.allReq_reg = req;
    assign bus.up_need    = upn_q;
    assign bus.down_need  = dnn_q;
    assign bus.cab_lamp   = cab_q;
    assign bus.up_lamp    = up_q;
    assign bus.dn_lamp    = dn_q;
endmodule

// File: tb/tb_request_scheduler.sv
// Scoreboard bench for request_scheduler: expected lamp/need
// snapshots are queued with each stimulus and popped at checkpoints.
module tb_request_scheduler;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    request_scheduler_if #(.N_FLOOR(4)) bus();

    request_scheduler #(.N_FLOOR(4), .SYNC_LEN(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string      tag;
        logic [3:0] cab;
        logic [3:0] up;
        logic [3:0] dn;
        logic       un;
        logic       dnn;
    } exp_t;

    exp_t sb[$];

    task automatic check_val(input string tag,
                             input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag,
                              input logic [3:0] cab,
                              input logic [3:0] up,
                              input logic [3:0] dn,
                              input logic un,
                              input logic dnn);
        exp_t e;
        e.tag = tag;
        e.cab = cab;
        e.up  = up;
        e.dn  = dn;
        e.un  = un;
        e.dnn = dnn;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            check_val("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check_val({e.tag, ".cab"}, 32'(bus.cab_lamp), 32'(e.cab));
            check_val({e.tag, ".up"}, 32'(bus.up_lamp), 32'(e.up));
            check_val({e.tag, ".dn"}, 32'(bus.dn_lamp), 32'(e.dn));
            check_val({e.tag, ".all"}, 32'(bus.allReq_reg),
                      32'(e.cab | e.up | e.dn));
            check_val({e.tag, ".upn"}, 32'(bus.up_need), 32'(e.un));
            check_val({e.tag, ".dnn"}, 32'(bus.down_need), 32'(e.dnn));
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] c,
                         input logic [3:0] u,
                         input logic [3:0] d);
        bus.cab_btn = c;
        bus.hall_up = u;
        bus.hall_dn = d;
        tick(1);
        bus.cab_btn = '0;
        bus.hall_up = '0;
        bus.hall_dn = '0;
    endtask

    task automatic reset_dut(input logic [3:0] p);
        bus.switch   = 1'b1;
        bus.opendoor = 1'b0;
        bus.cab_btn  = '0;
        bus.hall_up  = '0;
        bus.hall_dn  = '0;
        bus.position = p;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick(4);
    endtask

    initial begin
        // T1: reset with buttons held, no capture afterwards
        rst_n        = 1'b0;
        bus.switch   = 1'b1;
        bus.opendoor = 1'b0;
        bus.position = 4'b0001;
        bus.cab_btn  = 4'b1111;
        bus.hall_up  = 4'b0111;
        bus.hall_dn  = 4'b1110;
        expect_out("t1_rst", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        tick(2);
        check_out();
        rst_n = 1'b1;
        expect_out("t1_held", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        tick(8);
        check_out();
        bus.cab_btn = '0;
        bus.hall_up = '0;
        bus.hall_dn = '0;
        expect_out("t1_rel", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        tick(4);
        check_out();
        expect_out("t1_new", 4'b0100, 4'h0, 4'h0, 1'b0, 1'b0);
        press(4'b0100, 4'h0, 4'h0);
        tick(3);
        check_out();
        expect_out("t1_upn", 4'b0100, 4'h0, 4'h0, 1'b1, 1'b0);
        tick(1);
        check_out();
        bus.position = 4'b0100;
        bus.opendoor = 1'b1;
        expect_out("t1_srv", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        tick(1);
        check_out();

        // T2: cab request to floor 4 from floor 1
        reset_dut(4'b0001);
        expect_out("t2_lamp", 4'b1000, 4'h0, 4'h0, 1'b0, 1'b0);
        press(4'b1000, 4'h0, 4'h0);
        tick(3);
        check_out();
        expect_out("t2_upn", 4'b1000, 4'h0, 4'h0, 1'b1, 1'b0);
        tick(1);
        check_out();
        bus.position = 4'b1000;
        bus.opendoor = 1'b1;
        expect_out("t2_srv", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        tick(1);
        check_out();

        // T3: SCAN keeps going up past a request below
        reset_dut(4'b0010);
        expect_out("t3_lamp", 4'b1001, 4'h0, 4'h0, 1'b0, 1'b0);
        press(4'b1001, 4'h0, 4'h0);
        tick(3);
        check_out();
        expect_out("t3_hold", 4'b1001, 4'h0, 4'h0, 1'b1, 1'b0);
        tick(1);
        check_out();
        bus.position = 4'b1000;
        bus.opendoor = 1'b1;
        expect_out("t3_srv", 4'b0001, 4'h0, 4'h0, 1'b0, 1'b0);
        tick(1);
        check_out();
        bus.opendoor = 1'b0;
        expect_out("t3_down", 4'b0001, 4'h0, 4'h0, 1'b0, 1'b1);
        tick(1);
        check_out();
        rst_n = 1'b0;
        expect_out("t3_arst", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        #2;
        check_out();

        // T4: direction-aware hall clear, then invalid position
        reset_dut(4'b0100);
        expect_out("t4_lamp", 4'b1000, 4'b0100, 4'b0100, 1'b0, 1'b0);
        press(4'b1000, 4'b0100, 4'b0100);
        tick(3);
        check_out();
        expect_out("t4_upn", 4'b1000, 4'b0100, 4'b0100, 1'b1, 1'b0);
        tick(1);
        check_out();
        bus.opendoor = 1'b1;
        expect_out("t4_srv", 4'b1000, 4'h0, 4'b0100, 1'b0, 1'b0);
        tick(1);
        check_out();
        bus.position = 4'b0110;
        expect_out("t4_inv_od", 4'b1000, 4'h0, 4'b0100, 1'b0, 1'b0);
        tick(2);
        check_out();
        bus.opendoor = 1'b0;
        expect_out("t4_inv", 4'b1000, 4'h0, 4'b0100, 1'b0, 1'b0);
        tick(2);
        check_out();

        // T5: press absorbed while the door is open at that floor
        reset_dut(4'b0010);
        bus.opendoor = 1'b1;
        expect_out("t5_open", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        press(4'b0010, 4'h0, 4'h0);
        tick(5);
        check_out();
        bus.opendoor = 1'b0;
        expect_out("t5_close", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        tick(2);
        check_out();

        // T6: master switch flush and ignored hall buttons
        reset_dut(4'b0001);
        expect_out("t6_lamp", 4'b0100, 4'b0010, 4'b1000, 1'b0, 1'b0);
        press(4'b0100, 4'b0010, 4'b1000);
        tick(3);
        check_out();
        expect_out("t6_upn", 4'b0100, 4'b0010, 4'b1000, 1'b1, 1'b0);
        tick(1);
        check_out();
        bus.switch = 1'b0;
        expect_out("t6_off", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        tick(1);
        check_out();
        expect_out("t6_drop", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        press(4'b0010, 4'h0, 4'h0);
        tick(3);
        check_out();
        bus.switch = 1'b1;
        expect_out("t6_on", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        tick(3);
        check_out();
        expect_out("t6_ign", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        press(4'h0, 4'b1000, 4'b0001);
        tick(3);
        check_out();
        expect_out("t6_ign_n", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        tick(1);
        check_out();

        if (sb.size() != 0) check_val("sb_left", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
